// File: rtl/maze_mem_arbiter_if.sv
// maze_mem_arbiter_if: requester handshakes and memory command/response bus
// shared by the maze memory arbiter. The arbiter connects through the slave
// modport; requesters, the memory model and benches use the master view.
interface maze_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 1
);
  // Requester 0 (path-search controller) and requester 1 (loader/display)
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  // Single-port memory command and response
  logic          cen;
  logic          WR;
  logic          RD;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output cen, WR, RD, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  cen, WR, RD, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: shares the single-port maze memory between the path-search
// controller (requester 0) and the loader/display port (requester 1).
// One access per cycle, round-robin between requesters, with a bounded lock
// that lets the owner run up to MAX_LOCK back-to-back accesses. Read data
// returns one cycle after the grant on the issuing requester's rvalid.
// Optional macro ARB_FIXED_PRIO_EN: requester 0 always wins an idle contest.
module maze_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic               clk,
  input  logic               rst,
  maze_mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic [CW-1:0] r_lockCnt;
  logic          r_rvalid0;
  logic          r_rvalid1;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_cen;
  logic          w_wr;
  logic          w_rd;
  logic [AW-1:0] w_memAddr;
  logic [DW-1:0] w_memWdata;
  logic          w_lockMore;

  // Grant decision: the lock owner is the only candidate, otherwise contest
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
`ifdef ARB_FIXED_PRIO_EN
            w_gnt0 = 1'b1;
`else
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
`endif
          end else begin
            w_gnt0 = bus.req0;
            w_gnt1 = bus.req1;
          end
        end
        LOCK0:   w_gnt0 = bus.req0;
        LOCK1:   w_gnt1 = bus.req1;
        default: ;
      endcase
    end
  end

  // Memory command mux: the winner's request drives the memory this cycle
  always_comb begin
    w_cen      = 1'b0;
    w_wr       = 1'b0;
    w_rd       = 1'b0;
    w_memAddr  = {AW{1'b0}};
    w_memWdata = {DW{1'b0}};
    if (w_gnt0) begin
      w_cen      = 1'b1;
      w_wr       = bus.we0;
      w_rd       = ~bus.we0;
      w_memAddr  = bus.addr0;
      w_memWdata = bus.wdata0;
    end else if (w_gnt1) begin
      w_cen      = 1'b1;
      w_wr       = bus.we1;
      w_rd       = ~bus.we1;
      w_memAddr  = bus.addr1;
      w_memWdata = bus.wdata1;
    end
  end

  // The lock may continue only while the next grant stays within MAX_LOCK
  assign w_lockMore = (r_lockCnt < CW'(MAX_LOCK - 1));

  // Arbitration state, round-robin pointer, lock counter and read-return flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_lockCnt <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~bus.we0;
      r_rvalid1 <= w_gnt1 & ~bus.we1;
      if (w_gnt0) begin
        r_last <= 1'b0;
      end else if (w_gnt1) begin
        r_last <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_gnt0 && bus.lock0) begin
            r_state   <= LOCK0;
            r_lockCnt <= CW'(1);
          end else if (w_gnt1 && bus.lock1) begin
            r_state   <= LOCK1;
            r_lockCnt <= CW'(1);
          end
        end
        LOCK0: begin
          if (w_gnt0 && bus.lock0 && w_lockMore) begin
            r_lockCnt <= r_lockCnt + CW'(1);
          end else begin
            r_state   <= IDLE;
            r_lockCnt <= '0;
          end
        end
        LOCK1: begin
          if (w_gnt1 && bus.lock1 && w_lockMore) begin
            r_lockCnt <= r_lockCnt + CW'(1);
          end else begin
            r_state   <= IDLE;
            r_lockCnt <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_lockCnt <= '0;
        end
      endcase
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.cen       = w_cen;
  assign bus.WR        = w_wr;
  assign bus.RD        = w_rd;
  assign bus.mem_addr  = w_memAddr;
  assign bus.mem_wdata = w_memWdata;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// tb_maze_mem_arbiter: directed bench for the maze memory arbiter.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Strobe vectors are {gnt0, gnt1, cen, WR, RD}.
module tb_maze_mem_arbiter;
  localparam int AW       = 8;
  localparam int DW       = 1;
  localparam int MAX_LOCK = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] mem [0:255];

  maze_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  maze_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  wire [4:0] w_strb = {bus.gnt0, bus.gnt1, bus.cen, bus.WR, bus.RD};
  wire [1:0] w_rv   = {bus.rvalid0, bus.rvalid1};

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Memory model with one-cycle read latency
  always @(posedge clk) begin
    if (bus.RD) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic clearInputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.lock0 = 0; bus.lock1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic test_reset();
    bus.req0 = 1; bus.req1 = 1;
    #2;
    checks++;
    if (w_strb !== 5'b00000) begin failures++; $display("[TB] FAIL reset_strobes: got %b expected 00000", w_strb); end
    checks++;
    if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 1'b0) begin failures++; $display("[TB] FAIL reset_membus: got addr %h wdata %b expected 00/0", bus.mem_addr, bus.mem_wdata); end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (w_rv !== 2'b00) begin failures++; $display("[TB] FAIL reset_rvalid: got %b expected 00", w_rv); end
    clearInputs();
    rst = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h12;
    #1;
    checks++;
    if (w_strb !== 5'b10101) begin failures++; $display("[TB] FAIL read_strobes: got %b expected 10101", w_strb); end
    checks++;
    if (bus.mem_addr !== 8'h12) begin failures++; $display("[TB] FAIL read_addr: got %h expected 12", bus.mem_addr); end
    @(negedge clk);
    bus.req0 = 0;
    #1;
    checks++;
    if (w_rv !== 2'b10) begin failures++; $display("[TB] FAIL read_rvalid: got %b expected 10", w_rv); end
    checks++;
    if (bus.rdata0 !== 1'b1) begin failures++; $display("[TB] FAIL read_rdata0: got %b expected 1", bus.rdata0); end
    checks++;
    if (w_strb !== 5'b00000) begin failures++; $display("[TB] FAIL read_idle_strobes: got %b expected 00000", w_strb); end
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h40; bus.wdata1 = 1'b1;
    #1;
    checks++;
    if (w_strb !== 5'b01110) begin failures++; $display("[TB] FAIL write_strobes: got %b expected 01110", w_strb); end
    checks++;
    if (bus.mem_addr !== 8'h40 || bus.mem_wdata !== 1'b1) begin failures++; $display("[TB] FAIL write_membus: got addr %h wdata %b expected 40/1", bus.mem_addr, bus.mem_wdata); end
    @(negedge clk);
    clearInputs();
    #1;
    checks++;
    if (w_rv !== 2'b00) begin failures++; $display("[TB] FAIL write_no_rvalid: got %b expected 00", w_rv); end
  endtask

  task automatic test_contention();
    logic prev0;
    logic exp0;
    prev0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h20;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h21;
`ifdef ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (i % 2 == 0);
`endif
      #1;
      if (i > 0) begin
        checks++;
        if (w_rv !== (prev0 ? 2'b10 : 2'b01)) begin failures++; $display("[TB] FAIL cont_rvalid[%0d]: got %b expected %b", i, w_rv, prev0 ? 2'b10 : 2'b01); end
        checks++;
        if ((prev0 ? bus.rdata0 : bus.rdata1) !== prev0) begin failures++; $display("[TB] FAIL cont_rdata[%0d]: got %b expected %b", i, prev0 ? bus.rdata0 : bus.rdata1, prev0); end
      end
      checks++;
      if (w_strb !== (exp0 ? 5'b10101 : 5'b01101)) begin failures++; $display("[TB] FAIL cont_strobes[%0d]: got %b expected %b", i, w_strb, exp0 ? 5'b10101 : 5'b01101); end
      prev0 = exp0;
    end
    @(negedge clk);
    bus.req0 = 0;
    #1;
    checks++;
    if (w_rv !== (prev0 ? 2'b10 : 2'b01)) begin failures++; $display("[TB] FAIL cont_last_rvalid: got %b expected %b", w_rv, prev0 ? 2'b10 : 2'b01); end
    checks++;
    if (w_strb !== 5'b01101) begin failures++; $display("[TB] FAIL cont_req1_alone: got %b expected 01101", w_strb); end
    @(negedge clk);
    clearInputs();
    #1;
    checks++;
    if (w_rv !== 2'b01 || bus.rdata1 !== 1'b0) begin failures++; $display("[TB] FAIL cont_tail_rdata1: got rv %b data %b expected 01/0", w_rv, bus.rdata1); end
  endtask

  task automatic test_lock();
    @(negedge clk);
    bus.req1 = 1; bus.lock1 = 1; bus.we1 = 1; bus.addr1 = 8'h50;
    #1;
    checks++;
    if (w_strb !== 5'b01110) begin failures++; $display("[TB] FAIL lock_first: got %b expected 01110", w_strb); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h60;
      if (i == 2) bus.lock1 = 0;
      #1;
      checks++;
      if (w_strb !== 5'b01110) begin failures++; $display("[TB] FAIL lock_hold[%0d]: got %b expected 01110", i, w_strb); end
    end
    @(negedge clk);
    #1;
    checks++;
    if (w_strb !== 5'b10110) begin failures++; $display("[TB] FAIL lock_release: got %b expected 10110", w_strb); end
    @(negedge clk);
    clearInputs();
  endtask

  task automatic test_lock_abandon();
    @(negedge clk);
    bus.req0 = 1; bus.lock0 = 1; bus.we0 = 1;
    #1;
    checks++;
    if (w_strb !== 5'b10110) begin failures++; $display("[TB] FAIL abandon_grant0: got %b expected 10110", w_strb); end
    @(negedge clk);
    bus.req0 = 0; bus.lock0 = 0; bus.req1 = 1; bus.we1 = 1;
    #1;
    checks++;
    if (w_strb !== 5'b00000) begin failures++; $display("[TB] FAIL abandon_gap: got %b expected 00000", w_strb); end
    @(negedge clk);
    #1;
    checks++;
    if (w_strb !== 5'b01110) begin failures++; $display("[TB] FAIL abandon_grant1: got %b expected 01110", w_strb); end
    @(negedge clk);
    clearInputs();
  endtask

  task automatic test_forced_release();
    logic [4:0] exp16;
    int         bad;
    bad = 0;
    for (int i = 0; i < MAX_LOCK; i++) begin
      @(negedge clk);
      bus.req0 = 1; bus.lock0 = 1; bus.we0 = 1; bus.req1 = 1; bus.we1 = 1;
      #1;
      if (w_strb !== 5'b10110) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL forced_lock_run: got %0d cycles without gnt0 expected 0", bad); end
`ifdef ARB_FIXED_PRIO_EN
    exp16 = 5'b10110;
`else
    exp16 = 5'b01110;
`endif
    @(negedge clk);
    #1;
    checks++;
    if (w_strb !== exp16) begin failures++; $display("[TB] FAIL forced_release: got %b expected %b", w_strb, exp16); end
    @(negedge clk);
    #1;
    checks++;
    if (w_strb !== 5'b10110) begin failures++; $display("[TB] FAIL forced_relock: got %b expected 10110", w_strb); end
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    #1;
    checks++;
    if (w_strb !== 5'b00000) begin failures++; $display("[TB] FAIL forced_drain: got %b expected 00000", w_strb); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h21;
    #1;
    checks++;
    if (w_strb !== 5'b01101) begin failures++; $display("[TB] FAIL rstmid_grant1: got %b expected 01101", w_strb); end
    #1;
    rst = 0;
    #1;
    checks++;
    if (w_strb !== 5'b00000 || bus.mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_strobes: got %b addr %h expected 00000/00", w_strb, bus.mem_addr); end
    @(negedge clk);
    #1;
    checks++;
    if (w_rv !== 2'b00) begin failures++; $display("[TB] FAIL rstmid_rvalid: got %b expected 00", w_rv); end
    rst = 1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h12;
    #1;
    checks++;
    if (w_strb !== 5'b10101) begin failures++; $display("[TB] FAIL rstmid_first_gnt0: got %b expected 10101", w_strb); end
    @(negedge clk);
    clearInputs();
    #1;
    checks++;
    if (w_rv !== 2'b10 || bus.rdata0 !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_after_read: got rv %b data %b expected 10/1", w_rv, bus.rdata0); end
  endtask

  // Directed sequence; each task leaves inputs cleared for the next one
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 1'b0;
    mem[8'h12] = 1'b1;
    mem[8'h20] = 1'b1;
    mem[8'h21] = 1'b0;
    bus.mem_rdata = 1'b0;
    clearInputs();
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_lock();
    test_lock_abandon();
    test_forced_release();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
